// File: rtl/camera_pkg.sv
// Shared types and constants for the renderer camera controller.
package camera_pkg;

  localparam int FIXED_W = 32;
  localparam int FRAC    = 16;
  localparam int HEAD_W  = 6;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vec3_t;

  typedef struct packed {
    logic fwd;
    logic back;
    logic left;
    logic right;
    logic up;
    logic down;
    logic yaw_l;
    logic yaw_r;
  } btn_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_LUT,
    ST_MUL,
    ST_COMMIT
  } state_t;

  // Whole number to Q16.16.
  function automatic fixed_t to_fixed(input int whole);
    return fixed_t'(whole <<< FRAC);
  endfunction

endpackage

// File: rtl/camera_controller_if.sv
// Button inputs and camera outputs of the camera controller.
interface camera_controller_if;
  import camera_pkg::*;

  logic                frame_done_in;
  logic                btn_fwd_in;
  logic                btn_back_in;
  logic                btn_left_in;
  logic                btn_right_in;
  logic                btn_up_in;
  logic                btn_down_in;
  logic                btn_yaw_l_in;
  logic                btn_yaw_r_in;

  fixed_t              camera_x_out;
  fixed_t              camera_y_out;
  fixed_t              camera_z_out;
  fixed_t              camera_u_x_out;
  fixed_t              camera_u_y_out;
  fixed_t              camera_u_z_out;
  fixed_t              camera_v_x_out;
  fixed_t              camera_v_y_out;
  fixed_t              camera_v_z_out;
  fixed_t              camera_fwd_x_out;
  fixed_t              camera_fwd_y_out;
  fixed_t              camera_fwd_z_out;
  logic [HEAD_W-1:0]   heading_out;
  logic                busy_out;

  modport master (
    output frame_done_in, btn_fwd_in, btn_back_in, btn_left_in, btn_right_in,
           btn_up_in, btn_down_in, btn_yaw_l_in, btn_yaw_r_in,
    input  camera_x_out, camera_y_out, camera_z_out,
           camera_u_x_out, camera_u_y_out, camera_u_z_out,
           camera_v_x_out, camera_v_y_out, camera_v_z_out,
           camera_fwd_x_out, camera_fwd_y_out, camera_fwd_z_out,
           heading_out, busy_out
  );

  modport slave (
    input  frame_done_in, btn_fwd_in, btn_back_in, btn_left_in, btn_right_in,
           btn_up_in, btn_down_in, btn_yaw_l_in, btn_yaw_r_in,
    output camera_x_out, camera_y_out, camera_z_out,
           camera_u_x_out, camera_u_y_out, camera_u_z_out,
           camera_v_x_out, camera_v_y_out, camera_v_z_out,
           camera_fwd_x_out, camera_fwd_y_out, camera_fwd_z_out,
           heading_out, busy_out
  );

endinterface

// File: rtl/trig_lut.sv
// Registered sin/cos of a 64-step heading, built from a quarter-wave ROM.
module trig_lut
  import camera_pkg::*;
(
  input  logic              clk_in,
  input  logic [HEAD_W-1:0] head,
  output fixed_t            sin_p1,
  output fixed_t            cos_p1
);

  // sin(k*pi/32), k = 0..16, Q16.16 rounded to nearest.
  function automatic fixed_t quarter_rom(input logic [4:0] k);
    case (k)
      5'd0:    return 32'sd0;
      5'd1:    return 32'sd6424;
      5'd2:    return 32'sd12785;
      5'd3:    return 32'sd19024;
      5'd4:    return 32'sd25080;
      5'd5:    return 32'sd30893;
      5'd6:    return 32'sd36410;
      5'd7:    return 32'sd41576;
      5'd8:    return 32'sd46341;
      5'd9:    return 32'sd50660;
      5'd10:   return 32'sd54491;
      5'd11:   return 32'sd57798;
      5'd12:   return 32'sd60547;
      5'd13:   return 32'sd62714;
      5'd14:   return 32'sd64277;
      5'd15:   return 32'sd65220;
      5'd16:   return 32'sd65536;
      default: return 32'sd0;
    endcase
  endfunction

  // Bit 4 mirrors the quarter index, bit 5 negates the result.
  function automatic fixed_t sin_fold(input logic [HEAD_W-1:0] h);
    logic [4:0] idx;
    fixed_t     mag;
    idx = h[4] ? (5'd16 - {1'b0, h[3:0]}) : {1'b0, h[3:0]};
    mag = quarter_rom(idx);
    return h[5] ? -mag : mag;
  endfunction

  logic [HEAD_W-1:0] head_cos;
  assign head_cos = head + HEAD_W'(16);

  // Lookup stage: one-cycle registered read, cos(h) = sin(h + quarter turn).
  always_ff @(posedge clk_in) begin
    sin_p1 <= sin_fold(head);
    cos_p1 <= sin_fold(head_cos);
  end

endmodule

// File: rtl/camera_controller.sv
// Per-frame camera update: heading, movement, saturating position, atomic commit.
module camera_controller
  import camera_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in,
  camera_controller_if.slave bus
);

  typedef logic signed [FIXED_W+1:0] wide_t;

  localparam fixed_t STEP_FX      = to_fixed(1);
  localparam fixed_t FOCAL_FX     = to_fixed(150);
  localparam fixed_t POS_LIMIT_FX = to_fixed(1000);

  // Full-width signed product scaled back to Q16.16 (truncating).
  function automatic fixed_t fx_mul(input fixed_t a, input fixed_t b);
    logic signed [2*FIXED_W-1:0] prod;
    prod = a * b;
    prod = prod >>> FRAC;
    return prod[FIXED_W-1:0];
  endfunction

  // Clamp a widened sum to [-POS_LIMIT, +POS_LIMIT].
  function automatic fixed_t sat_pos(input wide_t v);
    if (v > wide_t'(POS_LIMIT_FX))  return POS_LIMIT_FX;
    if (v < -wide_t'(POS_LIMIT_FX)) return -POS_LIMIT_FX;
    return v[FIXED_W-1:0];
  endfunction

  // Signed contribution of an opposing button pair; both held cancels.
  function automatic wide_t contrib(input logic add, input logic sub, input fixed_t val);
    if (add && !sub) return wide_t'(val);
    if (sub && !add) return -wide_t'(val);
    return '0;
  endfunction

  function automatic logic [HEAD_W-1:0] next_head(input logic [HEAD_W-1:0] h,
                                                  input logic yaw_l, input logic yaw_r);
    if (yaw_r && !yaw_l) return h + HEAD_W'(1);
    if (yaw_l && !yaw_r) return h - HEAD_W'(1);
    return h;
  endfunction

  state_t            state_q, state_d;
  logic              busy;

  btn_t              btn_now;
  btn_t              btn_p0;
  logic [HEAD_W-1:0] head_p0;
  fixed_t            sin_p1, cos_p1;
  vec3_t             fwd_p2, u_p2, pos_p2;

  vec3_t             pos_q, u_q, fwd_q;
  logic [HEAD_W-1:0] head_q;

  fixed_t            step_s, step_c;
  wide_t             sum_x, sum_y, sum_z;

  assign btn_now = '{fwd:   bus.btn_fwd_in,   back:  bus.btn_back_in,
                     left:  bus.btn_left_in,  right: bus.btn_right_in,
                     up:    bus.btn_up_in,    down:  bus.btn_down_in,
                     yaw_l: bus.btn_yaw_l_in, yaw_r: bus.btn_yaw_r_in};

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Fixed five-state sequence; a pulse is only accepted in IDLE.
  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (bus.frame_done_in) state_d = ST_LATCH;
      end
      ST_LATCH:  state_d = ST_LUT;
      ST_LUT:    state_d = ST_MUL;
      ST_MUL:    state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  // ---- stage p0: buttons and new heading ----
  // Capture buttons and step the heading while in LATCH.
  always_ff @(posedge clk_in) begin
    if (state_q == ST_LATCH) begin
      btn_p0  <= btn_now;
      head_p0 <= next_head(head_q, btn_now.yaw_l, btn_now.yaw_r);
    end
  end

  // ---- stage p1: sin/cos of the new heading ----
  trig_lut u_trig (
    .clk_in (clk_in),
    .head   (head_p0),
    .sin_p1 (sin_p1),
    .cos_p1 (cos_p1)
  );

  // ---- stage p2: products and saturated position ----
  assign step_s = fx_mul(STEP_FX, sin_p1);
  assign step_c = fx_mul(STEP_FX, cos_p1);
  assign sum_x  = wide_t'(pos_q.x) + contrib(btn_p0.fwd, btn_p0.back, step_s)
                                   + contrib(btn_p0.right, btn_p0.left, step_c);
  assign sum_y  = wide_t'(pos_q.y) + contrib(btn_p0.up, btn_p0.down, STEP_FX);
  assign sum_z  = wide_t'(pos_q.z) + contrib(btn_p0.fwd, btn_p0.back, step_c)
                                   + contrib(btn_p0.left, btn_p0.right, step_s);

  // Register every product of the update during MUL.
  always_ff @(posedge clk_in) begin
    if (state_q == ST_MUL) begin
      fwd_p2 <= '{x: fx_mul(FOCAL_FX, sin_p1), y: '0, z: fx_mul(FOCAL_FX, cos_p1)};
      u_p2   <= '{x: cos_p1, y: '0, z: -sin_p1};
      pos_p2 <= '{x: sat_pos(sum_x), y: sat_pos(sum_y), z: sat_pos(sum_z)};
    end
  end

  // ---- commit: all camera outputs switch on one edge ----
  // Output registers; reset wins over a pending commit.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pos_q  <= '0;
      u_q    <= '{x: STEP_FX, y: '0, z: '0};
      fwd_q  <= '{x: '0, y: '0, z: FOCAL_FX};
      head_q <= '0;
    end else if (state_q == ST_COMMIT) begin
      pos_q  <= pos_p2;
      u_q    <= u_p2;
      fwd_q  <= fwd_p2;
      head_q <= head_p0;
    end
  end

  assign bus.camera_x_out     = pos_q.x;
  assign bus.camera_y_out     = pos_q.y;
  assign bus.camera_z_out     = pos_q.z;
  assign bus.camera_u_x_out   = u_q.x;
  assign bus.camera_u_y_out   = u_q.y;
  assign bus.camera_u_z_out   = u_q.z;
  assign bus.camera_v_x_out   = '0;
  assign bus.camera_v_y_out   = STEP_FX;
  assign bus.camera_v_z_out   = '0;
  assign bus.camera_fwd_x_out = fwd_q.x;
  assign bus.camera_fwd_y_out = fwd_q.y;
  assign bus.camera_fwd_z_out = fwd_q.z;
  assign bus.heading_out      = head_q;
  assign bus.busy_out         = busy;

endmodule

// File: tb/tb_camera_controller.sv
// Bench for camera_controller: directed steps plus random button frames against a trig model.
module tb_camera_controller;
  import camera_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  camera_controller_if bus();

  camera_controller dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  localparam longint ONE = 65536;
  localparam longint LIM = 1000 * 65536;

  // Reference model: heading index and position in Q16.16 integers.
  int     m_h;
  longint m_pos [3];

  function automatic longint msin(input int h);
    real s;
    s = $sin(2.0 * 3.14159265358979323846 * real'(h) / 64.0) * 65536.0;
    if (s >= 0.0) return longint'($rtoi(s + 0.5));
    return -longint'($rtoi(-s + 0.5));
  endfunction

  function automatic longint mcos(input int h);
    return msin((h + 16) % 64);
  endfunction

  function automatic longint clampl(input longint v);
    if (v > LIM)  return LIM;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0;
    for (int i = 0; i < 3; i++) m_pos[i] = 0;
  endtask

  // b = {fwd, back, left, right, up, down, yaw_l, yaw_r}
  task automatic model_step(input logic [7:0] b);
    longint s, c, fb, rl, ud;
    if (b[0] && !b[1])      m_h = (m_h + 1) % 64;
    else if (b[1] && !b[0]) m_h = (m_h + 63) % 64;
    s  = msin(m_h);
    c  = mcos(m_h);
    fb = longint'(b[7]) - longint'(b[6]);
    rl = longint'(b[4]) - longint'(b[5]);
    ud = longint'(b[3]) - longint'(b[2]);
    m_pos[0] = clampl(m_pos[0] + s * fb + c * rl);
    m_pos[1] = clampl(m_pos[1] + ONE * ud);
    m_pos[2] = clampl(m_pos[2] + c * fb - s * rl);
  endtask

  task automatic check_model(input string tag);
    longint s, c;
    s = msin(m_h);
    c = mcos(m_h);
    chk({tag, ".x"},     bus.camera_x_out,     32'(m_pos[0]));
    chk({tag, ".y"},     bus.camera_y_out,     32'(m_pos[1]));
    chk({tag, ".z"},     bus.camera_z_out,     32'(m_pos[2]));
    chk({tag, ".u_x"},   bus.camera_u_x_out,   32'(c));
    chk({tag, ".u_y"},   bus.camera_u_y_out,   32'(0));
    chk({tag, ".u_z"},   bus.camera_u_z_out,   32'(-s));
    chk({tag, ".v_x"},   bus.camera_v_x_out,   32'(0));
    chk({tag, ".v_y"},   bus.camera_v_y_out,   32'(ONE));
    chk({tag, ".v_z"},   bus.camera_v_z_out,   32'(0));
    chk({tag, ".fwd_x"}, bus.camera_fwd_x_out, 32'(150 * s));
    chk({tag, ".fwd_y"}, bus.camera_fwd_y_out, 32'(0));
    chk({tag, ".fwd_z"}, bus.camera_fwd_z_out, 32'(150 * c));
    chk({tag, ".head"},  32'(bus.heading_out), 32'(m_h));
  endtask

  task automatic set_btns(input logic [7:0] b);
    bus.btn_fwd_in   = b[7];
    bus.btn_back_in  = b[6];
    bus.btn_left_in  = b[5];
    bus.btn_right_in = b[4];
    bus.btn_up_in    = b[3];
    bus.btn_down_in  = b[2];
    bus.btn_yaw_l_in = b[1];
    bus.btn_yaw_r_in = b[0];
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.frame_done_in = 1'b0;
    set_btns(8'h00);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  // One frame_done pulse (optionally held a second cycle), busy length checked.
  task automatic do_frame(input logic [7:0] b, input bit extra);
    int cnt;
    @(negedge clk_in);
    set_btns(b);
    bus.frame_done_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    if (!extra) bus.frame_done_in = 1'b0;
    cnt = 0;
    while (bus.busy_out === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk_in);
      bus.frame_done_in = 1'b0;
    end
    chk("busy_len", 32'(cnt), 32'd4);
    model_step(b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_done_in = 1'b0;
    set_btns(8'h00);
    model_reset();

    // Reset, then idle.
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);
    check_model("reset");
    chk("reset.busy",  32'(bus.busy_out),         32'd0);
    chk("reset.fwd_z", bus.camera_fwd_z_out,      32'h0096_0000);
    chk("reset.u_x",   bus.camera_u_x_out,        32'h0001_0000);

    // Forward one step at heading 0.
    do_frame(8'b1000_0000, 1'b0);
    check_model("fwd1");
    chk("fwd1.z", bus.camera_z_out, 32'h0001_0000);

    // Yaw right 16 frames: quarter turn.
    for (int i = 0; i < 16; i++) do_frame(8'b0000_0001, 1'b0);
    check_model("yaw16");
    chk("yaw16.head",  32'(bus.heading_out),   32'd16);
    chk("yaw16.fwd_x", bus.camera_fwd_x_out,   32'h0096_0000);
    chk("yaw16.fwd_z", bus.camera_fwd_z_out,   32'h0000_0000);
    chk("yaw16.u_z",   bus.camera_u_z_out,     32'hFFFF_0000);

    // Yaw left twice from 0 wraps to 62.
    do_reset();
    do_frame(8'b0000_0010, 1'b0);
    do_frame(8'b0000_0010, 1'b0);
    check_model("yawl2");
    chk("yawl2.head", 32'(bus.heading_out), 32'd62);

    // Opposing fwd/back cancel, up moves; second pulse cycle is ignored.
    do_reset();
    do_frame(8'b1100_1000, 1'b1);
    repeat (6) begin
      @(negedge clk_in);
      chk("ignored.busy", 32'(bus.busy_out), 32'd0);
    end
    check_model("cancel");
    chk("cancel.y", bus.camera_y_out, 32'h0001_0000);

    // Saturation on y.
    do_reset();
    for (int i = 0; i < 1005; i++) begin
      do_frame(8'b0000_1000, 1'b0);
      if (i == 999) chk("sat1000.y", bus.camera_y_out, 32'h03E8_0000);
    end
    check_model("sat");
    chk("sat.y", bus.camera_y_out, 32'h03E8_0000);

    // Random button frames.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      do_frame(8'($urandom), 1'b0);
      check_model("rand");
    end

    // Reset landing during MUL discards the update.
    @(negedge clk_in);
    set_btns(8'b1001_0001);
    bus.frame_done_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    bus.frame_done_in = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    chk("rstmul.busy", 32'(bus.busy_out), 32'd0);
    check_model("rstmul");
    repeat (8) @(negedge clk_in);
    chk("rstmul_late.busy", 32'(bus.busy_out), 32'd0);
    check_model("rstmul_late");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/camera_controller.md
Name: camera_controller

Overview:
- Generates the per-frame camera (position, right vector u, up vector v, scaled forward vector) that feeds the raymarcher's camera inputs inside the renderer.
- Inputs are held user buttons. One update step runs per completed frame, triggered by the renderer's end-of-frame pulse.
- Outputs change atomically, in one cycle, after each update, so a rendered frame never mixes two camera states.

Parameters:
- STEP, 1.0 (fixed), translation distance per frame per held move button
- FOCAL, 150.0 (fixed), magnitude of the forward vector
- POS_LIMIT, 1000.0 (fixed), saturation bound on |camera_x|, |camera_y| and |camera_z|

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- frame_done_in  in  1  one-cycle pulse when the last pixel of a frame is written
- btn_fwd_in, btn_back_in, btn_left_in, btn_right_in, btn_up_in, btn_down_in  in  1 each  move buttons (level)
- btn_yaw_l_in, btn_yaw_r_in  in  1 each  heading buttons (level)
- camera_x_out, camera_y_out, camera_z_out  out  FIXED_W each  position
- camera_u_x_out, camera_u_y_out, camera_u_z_out  out  FIXED_W each  right vector
- camera_v_x_out, camera_v_y_out, camera_v_z_out  out  FIXED_W each  up vector
- camera_fwd_x_out, camera_fwd_y_out, camera_fwd_z_out  out  FIXED_W each  forward vector
- heading_out  out  HEAD_W  current heading index
- busy_out  out  1  update in progress

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is synchronous and active-high.
- Fixed point: signed, FIXED_W=32, FRAC=16 (Q16.16).
- Reset values:
  - position = 0
  - u = (1,0,0)
  - v = (0,1,0)
  - fwd = (0,0,FOCAL)
  - heading = 0
  - busy = 0
  - FSM = IDLE
- Heading: 6-bit index h; angle = h·2π/64.
  - yaw_r: h+1. yaw_l: h−1. Both held: no change.
  - Modulo-64 wrap: 63+1 → 0, 0−1 → 63.
- FSM sequence is IDLE → LATCH → LUT → MUL → COMMIT → IDLE.
  - IDLE: frame_done_in=1 → LATCH.
  - LATCH: register the buttons; compute the new h.
  - LUT: registered read of sin(h) and cos(h) from the trig sub-module.
  - MUL: compute the products below.
  - COMMIT: update all outputs in the same edge.
- Timing:
  - Pulse sampled at edge E0; new outputs visible after E4.
  - busy_out=1 after E0 through E3; busy_out=0 after E4.
- frame_done_in while busy_out=1 is ignored; it is not queued.
- Products:
  - Form a 2·FIXED_W signed product, arithmetic shift right by FRAC, truncate to FIXED_W.
  - fwd = FOCAL·(sin, 0, cos)
  - u = (cos, 0, −sin)
  - v = (0,1,0) always
- Movement uses the NEW heading:
  - Forward displacement = STEP·(sin, 0, cos). btn_fwd adds it; btn_back subtracts it.
  - Strafe displacement = STEP·(cos, 0, −sin). btn_right adds it; btn_left subtracts it.
  - btn_up adds STEP to y; btn_down subtracts STEP from y.
  - Opposing pair both held: that axis contributes 0.
  - All contributions are summed before saturation.
- Saturation: each position component is clamped to [−POS_LIMIT, +POS_LIMIT]. The sum is computed FIXED_W+2 wide so overflow is detected.
- rst_in in any state: FSM → IDLE, all outputs return to reset values on that edge, and the partial update is discarded.
- No buttons held: the update still runs. Outputs are rewritten with identical values, and busy timing is unchanged.

Decomposition:
- Package camera_pkg holds:
  - FIXED_W, FRAC, HEAD_W=6
  - typedef fixed_t (signed [FIXED_W-1:0])
  - typedef vec3_t (struct x,y,z of fixed_t)
  - to_fixed function
  - state enum
- Sub-module trig_lut:
  - Quarter-wave ROM of 17 entries (sin k·π/32, k=0..16, Q16.16).
  - Quadrant folding and sign logic.
  - One-cycle registered sin/cos outputs.
  - sin(0)=0, sin(16)=65536 exactly.

Test Plan:
- Reset, then idle 10 cycles → outputs equal reset values exactly (fwd_z=0x00960000, u_x=0x00010000), busy_out=0.
- btn_fwd held, one frame_done pulse at h=0 → busy_out high for exactly 4 cycles; camera_z=0x00010000; x=y=0.
- btn_yaw_r held for 16 pulses → h=16; fwd=(0x00960000,0,0); u=(0,0,0xFFFF0000). Two more pulses with yaw_l at h=0 → h=62.
- btn_fwd+btn_back+btn_up held, one pulse → x=z=0, y=0x00010000. frame_done reasserted on the cycle after the first pulse → ignored, only one update.
- btn_up held, 1005 pulses with POS_LIMIT=1000.0 → camera_y saturates at 0x03E80000 and stays there.
- rst_in asserted during the MUL state → next cycle all outputs equal reset values, busy_out=0, and no late COMMIT occurs.
